// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - register-file constants and writeback entry type
package rf_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_lookup.sv
// rtl/wb_lookup.sv - youngest-match bypass search over occupied queue entries
module wb_lookup
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  wb_entry_t         entries [DEPTH],
    input  logic [PW-1:0]     head,
    input  logic [CW-1:0]     count,
    input  logic [REG_AW-1:0] addr,
    output logic              hit,
    output logic [REG_DW-1:0] data
);

    logic [PW-1:0] idx;

    // Walk from oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (addr != REG_ZERO) && (entries[idx].rd == addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - ALU/load result queue issuing one register-file write per cycle
module reg_writeback_queue
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_rd,
    input  logic [DW-1:0]            alu_data,
    input  logic                     mem_valid,
    input  logic [AW-1:0]            mem_rd,
    input  logic [DW-1:0]            mem_data,
    output logic                     in_ready,
    output logic                     write_en,
    output logic [AW-1:0]            write_addr,
    output logic [DW-1:0]            write_data,
    input  logic [AW-1:0]            lookup_addr_1,
    input  logic [AW-1:0]            lookup_addr_2,
    output logic                     lookup_hit_1,
    output logic                     lookup_hit_2,
    output logic [DW-1:0]            lookup_data_1,
    output logic [DW-1:0]            lookup_data_2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t     entries_q [DEPTH];
    wb_entry_t     entries_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          mem_ok, alu_ok;
    logic [CW-1:0] n_enq;
    logic [PW-1:0] alu_slot;

    assign in_ready   = (count_q <= CW'(DEPTH - 2));
    assign write_en   = (count_q != '0);
    assign write_addr = entries_q[head_q].rd;
    assign write_data = entries_q[head_q].data;
    assign count      = count_q;

    // x0 results are acknowledged but never occupy a slot.
    assign mem_ok   = in_ready && mem_valid && (mem_rd != REG_ZERO);
    assign alu_ok   = in_ready && alu_valid && (alu_rd != REG_ZERO);
    assign n_enq    = {{(CW-1){1'b0}}, mem_ok} + {{(CW-1){1'b0}}, alu_ok};
    assign alu_slot = tail_q + PW'(mem_ok);

    always_comb begin
        entries_d = entries_q;
        if (mem_ok) begin
            entries_d[tail_q] = '{rd: mem_rd, data: mem_data};
        end
        if (alu_ok) begin
            entries_d[alu_slot] = '{rd: alu_rd, data: alu_data};
        end
        head_d  = head_q + PW'(write_en);
        tail_d  = tail_q + PW'(n_enq);
        count_d = count_q + n_enq - CW'(write_en);
    end

    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    wb_lookup #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_lookup_1 (
        .entries (entries_q),
        .head    (head_q),
        .count   (count_q),
        .addr    (lookup_addr_1),
        .hit     (lookup_hit_1),
        .data    (lookup_data_1)
    );

    wb_lookup #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_lookup_2 (
        .entries (entries_q),
        .head    (head_q),
        .count   (count_q),
        .addr    (lookup_addr_2),
        .hit     (lookup_hit_2),
        .data    (lookup_data_2)
    );

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb/tb_reg_writeback_queue.sv - directed self-checking bench for reg_writeback_queue
module tb_reg_writeback_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        in_ready, write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  lookup_addr_1, lookup_addr_2;
    logic        lookup_hit_1, lookup_hit_2;
    logic [31:0] lookup_data_1, lookup_data_2;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_writeback_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .in_ready      (in_ready),
        .write_en      (write_en),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .lookup_addr_1 (lookup_addr_1),
        .lookup_addr_2 (lookup_addr_2),
        .lookup_hit_1  (lookup_hit_1),
        .lookup_hit_2  (lookup_hit_2),
        .lookup_data_1 (lookup_data_1),
        .lookup_data_2 (lookup_data_2),
        .count         (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic av, input logic [4:0] ar, input logic [31:0] ad);
        mem_valid = mv; mem_rd = mr; mem_data = md;
        alu_valid = av; alu_rd = ar; alu_data = ad;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic check_write(input string tag, input logic [2:0] exp_count,
                               input logic [4:0] exp_addr, input logic [31:0] exp_data);
        check({tag, "_count"}, 32'(count), 32'(exp_count));
        check({tag, "_wen"},   32'(write_en), 32'(exp_count != 3'd0));
        check({tag, "_addr"},  32'(write_addr), 32'(exp_addr));
        check({tag, "_data"},  write_data, exp_data);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        lookup_addr_1 = 5'd5;
        lookup_addr_2 = 5'd0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("rst_count",    32'(count), 32'd0);
        check("rst_wen",      32'(write_en), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_hit1",     32'(lookup_hit_1), 32'd0);
        check("rst_data1",    lookup_data_1, 32'd0);
        check("rst_hit2",     32'(lookup_hit_2), 32'd0);

        // single ALU result
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hDEADBEEF);
        step();
        idle();
        lookup_addr_1 = 5'd3;
        lookup_addr_2 = 5'd3;
        #1;
        check_write("alu1", 3'd1, 5'd3, 32'hDEADBEEF);
        check("alu1_hit1",  32'(lookup_hit_1), 32'd1);
        check("alu1_data1", lookup_data_1, 32'hDEADBEEF);
        check("alu1_hit2",  32'(lookup_hit_2), 32'd1);
        step();
        check("alu1_done_count", 32'(count), 32'd0);
        check("alu1_done_wen",   32'(write_en), 32'd0);
        check("alu1_done_hit1",  32'(lookup_hit_1), 32'd0);
        check("alu1_done_data1", lookup_data_1, 32'd0);

        // same-cycle mem and alu to the same rd: mem is older
        drive(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
        step();
        idle();
        lookup_addr_1 = 5'd7;
        lookup_addr_2 = 5'd0;
        #1;
        check_write("dup0", 3'd2, 5'd7, 32'h11);
        check("dup0_data1", lookup_data_1, 32'h22);
        check("dup0_hit2",  32'(lookup_hit_2), 32'd0);
        step();
        check_write("dup1", 3'd1, 5'd7, 32'h22);
        check("dup1_data1", lookup_data_1, 32'h22);
        step();
        check("dup2_count", 32'(count), 32'd0);

        // x0 result is dropped
        drive(1'b1, 5'd4, 32'h66, 1'b1, 5'd0, 32'h55);
        step();
        idle();
        check_write("x0", 3'd1, 5'd4, 32'h66);
        step();
        check("x0_done_count", 32'(count), 32'd0);

        // fill: second pair leaves one slot free, third pair ignored
        drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102);
        step();
        check_write("fill0", 3'd2, 5'd1, 32'h101);
        check("fill0_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 5'd3, 32'h103, 1'b1, 5'd4, 32'h104);
        step();
        check_write("fill1", 3'd3, 5'd2, 32'h102);
        check("fill1_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 5'd5, 32'h105, 1'b1, 5'd6, 32'h106);
        step();
        idle();
        check_write("fill2", 3'd2, 5'd3, 32'h103);
        step();
        check_write("fill3", 3'd1, 5'd4, 32'h104);
        step();
        check("fill4_count", 32'(count), 32'd0);
        check("fill4_wen",   32'(write_en), 32'd0);

        // six more entries wrap the pointers
        drive(1'b1, 5'd10, 32'h10A, 1'b1, 5'd11, 32'h10B);
        step();
        check_write("wrap0", 3'd2, 5'd10, 32'h10A);
        drive(1'b1, 5'd12, 32'h10C, 1'b1, 5'd13, 32'h10D);
        step();
        idle();
        check_write("wrap1", 3'd3, 5'd11, 32'h10B);
        step();
        check_write("wrap2", 3'd2, 5'd12, 32'h10C);
        drive(1'b1, 5'd14, 32'h10E, 1'b1, 5'd15, 32'h10F);
        step();
        idle();
        lookup_addr_1 = 5'd14;
        lookup_addr_2 = 5'd13;
        #1;
        check_write("wrap3", 3'd3, 5'd13, 32'h10D);
        check("wrap3_data1", lookup_data_1, 32'h10E);
        check("wrap3_data2", lookup_data_2, 32'h10D);
        step();
        check_write("wrap4", 3'd2, 5'd14, 32'h10E);
        step();
        check_write("wrap5", 3'd1, 5'd15, 32'h10F);
        step();
        check("wrap6_count", 32'(count), 32'd0);

        // async reset mid-drain
        drive(1'b1, 5'd20, 32'h114, 1'b1, 5'd21, 32'h115);
        step();
        drive(1'b1, 5'd22, 32'h116, 1'b1, 5'd23, 32'h117);
        step();
        idle();
        lookup_addr_1 = 5'd22;
        check("pre_rst_count", 32'(count), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_wen",   32'(write_en), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_hit1",  32'(lookup_hit_1), 32'd0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_wen", 32'(write_en), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Write-side initiator for the 32x32 register file: collects results from the ALU and the load unit, queues them, and issues at most one register-file write per cycle on write_en/write_addr/write_data.
- Provides two bypass lookup ports so decode can see values that are still queued and not yet written.
- Sits between the execute/memory stages and the register file.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of 2 and at least 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- mem_valid  in  1  load result present this cycle.
- mem_rd  in  AW  load destination register.
- mem_data  in  DW  load result.
- in_ready  out  1  queue can accept both producers this cycle.
- write_en  out  1  register-file write strobe.
- write_addr  out  AW  register-file write address.
- write_data  out  DW  register-file write data.
- lookup_addr_1, lookup_addr_2  in  AW  bypass lookup addresses (rs1, rs2).
- lookup_hit_1, lookup_hit_2  out  1  a pending entry matches.
- lookup_data_1, lookup_data_2  out  DW  data of the youngest matching entry.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (async, rst_n=0):
  - count=0 and head/tail pointers=0.
  - write_en=0 and in_ready=1.
  - lookup_hit_*=0.
  - Entry contents are don't-care.
  - Reset asserted mid-operation discards all pending writes; none reach the register file.
- in_ready:
  - Combinational from registered count only: in_ready = (DEPTH - count >= 2).
  - Does not depend on valids or the current dequeue.
- Enqueue (rising edge, in_ready=1):
  - mem entry is older than the alu entry; when both are valid, mem goes to tail and alu to tail+1.
  - A valid with rd=0 is accepted but not stored, because x0 is never written.
  - Valids with in_ready=0 are ignored; producers hold their data until in_ready is high.
- Dequeue:
  - write_en = (count != 0), combinational.
  - write_addr/write_data come from the head entry.
  - The register file never stalls, so the head pops every cycle write_en=1.
  - Throughput is 1 write per cycle.
- Count update: count_next = count + n_enq - (write_en ? 1 : 0), where n_enq is 0..2 after x0 filtering.
  - Simultaneous enqueue and dequeue are legal.
  - Enqueue into a full queue cannot happen, because in_ready gates it.
- Pointer wrap-around: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Latency:
  - An entry enqueued at edge N appears at write_* in cycle N (after edge N) if the queue was empty; otherwise it follows the older entries in order.
  - The register file commits it at the following edge.
- Bypass:
  - Combinational search over all occupied entries, including the head being written this cycle.
  - Youngest match wins.
  - lookup_addr=0 always gives hit=0.
  - No hit: hit=0, data=0.
  - Same-cycle incoming alu/mem values are not visible through lookup; decode handles those through execute forwarding.
- Duplicate rd across entries is legal. Writes occur in order, so the register file ends with the youngest value.

Decomposition:
- Shared package rf_pkg holds:
  - constants REG_AW=5, REG_DW=32, REG_ZERO=5'd0;
  - typedef wb_entry_t (struct: rd, data).
- One sub-module, wb_lookup, is natural: a parameterised youngest-match priority search over the entry array, instantiated twice (one per lookup port).

Test Plan:
- Reset then idle: count=0, write_en=0, in_ready=1; lookup_addr_1=5 gives hit_1=0, data_1=0.
- Single ALU write (alu_rd=3, alu_data=0xDEADBEEF) -> next cycle write_en=1, write_addr=3, write_data=0xDEADBEEF, lookup_addr_1=3 hits with 0xDEADBEEF; following cycle count=0, write_en=0.
- Same cycle mem(rd=7, 0x11) and alu(rd=7, 0x22):
  - writes issue in order 7<-0x11 then 7<-0x22;
  - while both are pending, lookup(7) returns 0x22;
  - after the first write, lookup(7) still returns 0x22.
- x0 filter: alu_rd=0 (data 0x55) with mem_rd=4 (data 0x66) -> count increments by 1 only; only 4<-0x66 is written.
- Fill with DEPTH=4, both producers valid for 2 cycles (rds 1,2,3,4):
  - count=3 after the second edge (4 enqueued, 1 drained);
  - in_ready=0 because only 1 entry is free, so the third-cycle valids (rds 5, 6) are ignored;
  - drain order is 1, 2, 3, 4;
  - pointer wrap is exercised with a further 6 entries.
- Async reset asserted mid-drain with count=3 -> write_en=0 and count=0 immediately, without waiting for a clock edge; no further writes after release.
